// File: rtl/branch_predictor_pkg.sv
// branch_predictor_pkg: opcode constants, 2-bit counter encodings and the
// saturating counter update shared by the predictor and its history table.
package branch_predictor_pkg;

    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        CNT_SNT = 2'b00,
        CNT_WNT = 2'b01,
        CNT_WT  = 2'b10,
        CNT_ST  = 2'b11
    } cnt_e;

    function automatic logic [1:0] cnt_next(input logic [1:0] cur, input logic taken);
        if (taken)
            return (cur == CNT_ST) ? cur : cur + 2'd1;
        return (cur == CNT_SNT) ? cur : cur - 2'd1;
    endfunction

endpackage

// File: rtl/bht_counter_table.sv
// bht_counter_table: flop-based table of 2-bit saturating counters with one
// combinational read port and one synchronous update port.
module bht_counter_table
    import branch_predictor_pkg::*;
#(
    parameter int         IDX_W     = 6,
    parameter logic [1:0] RESET_CNT = 2'b01
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [1:0]       rd_cnt,
    input  logic             upd_valid,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken
);

    localparam int DEPTH = 1 << IDX_W;

    logic [1:0] cnt_q [DEPTH];
    logic [1:0] cnt_d [DEPTH];

    // Read sees the stored value, so a same-cycle update is not bypassed
    assign rd_cnt = cnt_q[rd_idx];

    always_comb begin
        cnt_d = cnt_q;
        if (upd_valid)
            cnt_d[upd_idx] = cnt_next(cnt_q[upd_idx], upd_taken);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                cnt_q[i] <= RESET_CNT;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: single-cycle next-PC predictor for one fetch slot, using
// static JAL/JALR targets and a bimodal history table for conditional branches.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int         BHT_IDX_W = 6,
    parameter logic [1:0] RESET_CNT = 2'b01
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        f_valid,
    input  logic [31:0] f_pc,
    input  logic [31:0] f_inst,
    input  logic        stall,
    input  logic        flush,
    output logic [4:0]  rs1pred,
    input  logic [31:0] data_rs1pred,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    output logic        p_valid,
    output logic [31:0] p_pc,
    output logic [31:0] p_npc,
    output logic        p_taken
);

    logic [1:0]  cnt_rd;
    logic [31:0] rs1_val, imm_j, imm_i, imm_b, npc;
    logic        taken;

    logic        p_valid_q, p_valid_d;
    logic [31:0] p_pc_q, p_pc_d;
    logic [31:0] p_npc_q, p_npc_d;
    logic        p_taken_q, p_taken_d;

    assign rs1pred = f_inst[19:15];

    bht_counter_table #(
        .IDX_W     (BHT_IDX_W),
        .RESET_CNT (RESET_CNT)
    ) u_bht (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_idx    (f_pc[BHT_IDX_W:1]),
        .rd_cnt    (cnt_rd),
        .upd_valid (upd_valid),
        .upd_idx   (upd_pc[BHT_IDX_W:1]),
        .upd_taken (upd_taken)
    );

    always_comb begin
        imm_j   = {{12{f_inst[31]}}, f_inst[19:12], f_inst[20], f_inst[30:21], 1'b0};
        imm_i   = {{20{f_inst[31]}}, f_inst[31:20]};
        imm_b   = {{20{f_inst[31]}}, f_inst[7], f_inst[30:25], f_inst[11:8], 1'b0};
        rs1_val = (rs1pred == 5'd0) ? 32'd0 : data_rs1pred;
        npc     = f_pc + 32'd4;
        taken   = 1'b0;
        if (f_inst[1:0] != 2'b11) begin
            npc = f_pc + 32'd2;
        end else if (f_inst[6:0] == OPC_JAL) begin
            npc   = f_pc + imm_j;
            taken = 1'b1;
        end else if (f_inst[6:0] == OPC_JALR) begin
            npc   = (rs1_val + imm_i) & ~32'd1;
            taken = 1'b1;
        end else if (f_inst[6:0] == OPC_BRANCH && cnt_rd[1]) begin
            npc   = f_pc + imm_b;
            taken = 1'b1;
        end
    end

    // Flush only kills validity; the payload is don't-care so it loads freely
    always_comb begin
        p_valid_d = flush ? 1'b0 : stall ? p_valid_q : f_valid;
        p_pc_d    = stall ? p_pc_q    : f_pc;
        p_npc_d   = stall ? p_npc_q   : npc;
        p_taken_d = stall ? p_taken_q : taken;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_valid_q <= 1'b0;
            p_pc_q    <= 32'd0;
            p_npc_q   <= 32'd0;
            p_taken_q <= 1'b0;
        end else begin
            p_valid_q <= p_valid_d;
            p_pc_q    <= p_pc_d;
            p_npc_q   <= p_npc_d;
            p_taken_q <= p_taken_d;
        end
    end

    assign p_valid = p_valid_q;
    assign p_pc    = p_pc_q;
    assign p_npc   = p_npc_q;
    assign p_taken = p_taken_q;

endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed scenarios plus randomized traffic checked
// against a behavioural next-PC and counter model.
module tb_branch_predictor;

    localparam int K_OTHER = 0, K_COMP = 1, K_JAL = 2, K_JALR = 3, K_BR = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        f_valid = 1'b0;
    logic [31:0] f_pc = '0;
    logic [31:0] f_inst = '0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [4:0]  rs1pred;
    logic [31:0] data_rs1pred = '0;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = '0;
    logic        upd_taken = 1'b0;
    logic        p_valid;
    logic [31:0] p_pc;
    logic [31:0] p_npc;
    logic        p_taken;

    int n_cmp = 0;
    int n_fail = 0;

    int          cnt [64];
    int          m_kind;
    logic [31:0] m_imm;
    logic [4:0]  m_rs;
    logic        exp_valid, exp_taken;
    logic [31:0] exp_pc, exp_npc;

    always #5 clk = ~clk;

    branch_predictor dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .f_valid      (f_valid),
        .f_pc         (f_pc),
        .f_inst       (f_inst),
        .stall        (stall),
        .flush        (flush),
        .rs1pred      (rs1pred),
        .data_rs1pred (data_rs1pred),
        .upd_valid    (upd_valid),
        .upd_pc       (upd_pc),
        .upd_taken    (upd_taken),
        .p_valid      (p_valid),
        .p_pc         (p_pc),
        .p_npc        (p_npc),
        .p_taken      (p_taken)
    );

    task automatic model_reset();
        for (int i = 0; i < 64; i++) cnt[i] = 1;
        exp_valid = 1'b0;
        exp_pc    = '0;
        exp_npc   = '0;
        exp_taken = 1'b0;
    endtask

    task automatic set_fetch(input int kind, input logic [31:0] pc, input logic [31:0] imm,
                             input logic [4:0] rs, input logic [31:0] data);
        logic [31:0] w;
        w = $urandom;
        case (kind)
            K_COMP: if (w[1:0] == 2'b11) w[1:0] = 2'b01;
            K_JAL:  w = {imm[20], imm[10:1], imm[11], imm[19:12], 5'd1, 7'b1101111};
            K_JALR: w = {imm[11:0], rs, 3'b000, 5'd1, 7'b1100111};
            K_BR:   w = {imm[12], imm[10:5], 5'd2, rs, 3'b000, imm[4:1], imm[11], 7'b1100011};
            default: begin
                w[1:0] = 2'b11;
                if (w[6:0] == 7'b1101111 || w[6:0] == 7'b1100111 || w[6:0] == 7'b1100011)
                    w[6:0] = 7'b0110011;
            end
        endcase
        f_valid      = 1'b1;
        f_pc         = pc;
        f_inst       = w;
        data_rs1pred = data;
        m_kind       = kind;
        m_imm        = imm;
        m_rs         = w[19:15];
    endtask

    task automatic tick();
        logic [31:0] npc;
        logic        tk;
        int          u;
        npc = f_pc + 32'd4;
        tk  = 1'b0;
        case (m_kind)
            K_COMP: npc = f_pc + 32'd2;
            K_JAL:  begin npc = f_pc + m_imm; tk = 1'b1; end
            K_JALR: begin npc = (((m_rs == 0) ? 32'd0 : data_rs1pred) + m_imm) & 32'hFFFF_FFFE; tk = 1'b1; end
            K_BR:   if (cnt[(f_pc >> 1) % 64] >= 2) begin npc = f_pc + m_imm; tk = 1'b1; end
            default: ;
        endcase
        @(posedge clk);
        if (flush) exp_valid = 1'b0;
        else if (!stall) begin
            exp_valid = f_valid;
            exp_pc    = f_pc;
            exp_npc   = npc;
            exp_taken = tk;
        end
        if (upd_valid) begin
            u = (upd_pc >> 1) % 64;
            if (upd_taken) cnt[u] = (cnt[u] == 3) ? 3 : cnt[u] + 1;
            else           cnt[u] = (cnt[u] == 0) ? 0 : cnt[u] - 1;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        model_reset();
        m_kind = K_OTHER;
        #3;
        n_cmp++; if (p_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b want 0", p_valid); end
        n_cmp++; if (p_pc !== 32'd0)   begin n_fail++; $display("FAIL reset_pc got %h want 0", p_pc); end
        n_cmp++; if (p_npc !== 32'd0)  begin n_fail++; $display("FAIL reset_npc got %h want 0", p_npc); end
        n_cmp++; if (p_taken !== 1'b0) begin n_fail++; $display("FAIL reset_taken got %0b want 0", p_taken); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_jal();
        set_fetch(K_JAL, 32'h100, 32'h20, 5'd0, 32'd0);
        tick();
        n_cmp++; if (p_valid !== 1'b1)     begin n_fail++; $display("FAIL jal_valid got %0b want 1", p_valid); end
        n_cmp++; if (p_pc !== 32'h100)     begin n_fail++; $display("FAIL jal_pc got %h want 00000100", p_pc); end
        n_cmp++; if (p_npc !== 32'h120)    begin n_fail++; $display("FAIL jal_npc got %h want 00000120", p_npc); end
        n_cmp++; if (p_taken !== 1'b1)     begin n_fail++; $display("FAIL jal_taken got %0b want 1", p_taken); end
    endtask

    task automatic test_jalr();
        set_fetch(K_JALR, 32'h200, 32'd4, 5'd5, 32'h2003);
        n_cmp++; if (rs1pred !== 5'd5)     begin n_fail++; $display("FAIL jalr_rs1pred got %0d want 5", rs1pred); end
        tick();
        n_cmp++; if (p_npc !== 32'h2006)   begin n_fail++; $display("FAIL jalr_npc got %h want 00002006", p_npc); end
        n_cmp++; if (p_taken !== 1'b1)     begin n_fail++; $display("FAIL jalr_taken got %0b want 1", p_taken); end
        set_fetch(K_JALR, 32'h204, 32'h7FF, 5'd0, 32'hFFFF);
        tick();
        n_cmp++; if (p_npc !== 32'h7FE)    begin n_fail++; $display("FAIL jalr_x0_npc got %h want 000007fe", p_npc); end
        set_fetch(K_JALR, 32'h208, 32'hFFFF_FFF0, 5'd7, 32'h5);
        tick();
        n_cmp++; if (p_npc !== exp_npc)    begin n_fail++; $display("FAIL jalr_neg_npc got %h want %h", p_npc, exp_npc); end
    endtask

    task automatic test_branch_training();
        logic [31:0] m8;
        m8 = 32'hFFFF_FFF8;
        set_fetch(K_BR, 32'h40, m8, 5'd3, 32'd0);
        tick();
        n_cmp++; if (p_npc !== 32'h44)     begin n_fail++; $display("FAIL br_init_npc got %h want 00000044", p_npc); end
        n_cmp++; if (p_taken !== 1'b0)     begin n_fail++; $display("FAIL br_init_taken got %0b want 0", p_taken); end
        f_valid = 1'b0; upd_valid = 1'b1; upd_pc = 32'h40; upd_taken = 1'b1;
        tick();
        upd_valid = 1'b0;
        set_fetch(K_BR, 32'h40, m8, 5'd3, 32'd0);
        tick();
        n_cmp++; if (p_npc !== 32'h38)     begin n_fail++; $display("FAIL br_trained_npc got %h want 00000038", p_npc); end
        n_cmp++; if (p_taken !== 1'b1)     begin n_fail++; $display("FAIL br_trained_taken got %0b want 1", p_taken); end
        f_valid = 1'b0; upd_valid = 1'b1; upd_taken = 1'b1;
        repeat (3) tick();
        upd_taken = 1'b0;
        tick();
        upd_valid = 1'b0;
        set_fetch(K_BR, 32'h40, m8, 5'd3, 32'd0);
        tick();
        n_cmp++; if (p_taken !== 1'b1)     begin n_fail++; $display("FAIL br_hyst_taken got %0b want 1", p_taken); end
        n_cmp++; if (p_npc !== 32'h38)     begin n_fail++; $display("FAIL br_hyst_npc got %h want 00000038", p_npc); end
    endtask

    task automatic test_collision();
        logic [31:0] m8;
        m8 = 32'hFFFF_FFF8;
        set_fetch(K_BR, 32'h40, m8, 5'd3, 32'd0);
        upd_valid = 1'b1; upd_pc = 32'h40; upd_taken = 1'b0;
        tick();
        upd_valid = 1'b0;
        n_cmp++; if (p_taken !== 1'b1)     begin n_fail++; $display("FAIL coll_same_taken got %0b want 1", p_taken); end
        tick();
        n_cmp++; if (p_taken !== 1'b0)     begin n_fail++; $display("FAIL coll_next_taken got %0b want 0", p_taken); end
        n_cmp++; if (p_npc !== 32'h44)     begin n_fail++; $display("FAIL coll_next_npc got %h want 00000044", p_npc); end
    endtask

    task automatic test_stall_flush();
        set_fetch(K_JAL, 32'h100, 32'h20, 5'd0, 32'd0);
        tick();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_fetch(K_COMP, 32'h300 + i * 2, 32'd0, 5'd0, 32'd0);
            f_valid = i[0];
            tick();
            n_cmp++; if (p_valid !== 1'b1)  begin n_fail++; $display("FAIL stall_valid[%0d] got %0b want 1", i, p_valid); end
            n_cmp++; if (p_pc !== 32'h100)  begin n_fail++; $display("FAIL stall_pc[%0d] got %h want 00000100", i, p_pc); end
            n_cmp++; if (p_npc !== 32'h120) begin n_fail++; $display("FAIL stall_npc[%0d] got %h want 00000120", i, p_npc); end
            n_cmp++; if (p_taken !== 1'b1)  begin n_fail++; $display("FAIL stall_taken[%0d] got %0b want 1", i, p_taken); end
        end
        flush = 1'b1;
        tick();
        n_cmp++; if (p_valid !== 1'b0)     begin n_fail++; $display("FAIL flush_valid got %0b want 0", p_valid); end
        stall = 1'b0; flush = 1'b0;
        set_fetch(K_COMP, 32'hFFFF_FFFE, 32'd0, 5'd0, 32'd0);
        tick();
        n_cmp++; if (p_valid !== 1'b1)     begin n_fail++; $display("FAIL wrap_valid got %0b want 1", p_valid); end
        n_cmp++; if (p_npc !== 32'd0)      begin n_fail++; $display("FAIL wrap_npc got %h want 00000000", p_npc); end
        n_cmp++; if (p_taken !== 1'b0)     begin n_fail++; $display("FAIL wrap_taken got %0b want 0", p_taken); end
    endtask

    task automatic test_random();
        int kind;
        logic [31:0] r, imm, pc;
        for (int c = 0; c < 400; c++) begin
            kind = $urandom_range(0, 4);
            r    = $urandom;
            pc   = {$urandom} & 32'hFFFF_FFFE;
            case (kind)
                K_JAL:  imm = {{11{r[20]}}, r[20:1], 1'b0};
                K_JALR: imm = {{20{r[11]}}, r[11:0]};
                K_BR:   begin imm = {{19{r[12]}}, r[12:1], 1'b0}; if (r[31]) pc = 32'h40 + 2 * $urandom_range(0, 3); end
                default: imm = '0;
            endcase
            set_fetch(kind, pc, imm, 5'($urandom_range(0, 3)), $urandom);
            f_valid   = ($urandom_range(0, 3) != 0);
            stall     = ($urandom_range(0, 7) == 0);
            flush     = ($urandom_range(0, 15) == 0);
            upd_valid = $urandom_range(0, 1);
            upd_pc    = 32'h40 + 2 * $urandom_range(0, 3);
            upd_taken = $urandom_range(0, 1);
            tick();
            n_cmp++; if (p_valid !== exp_valid) begin n_fail++; $display("FAIL rand_valid[%0d] got %0b want %0b", c, p_valid, exp_valid); end
            if (exp_valid) begin
                n_cmp++; if (p_pc !== exp_pc)       begin n_fail++; $display("FAIL rand_pc[%0d] got %h want %h", c, p_pc, exp_pc); end
                n_cmp++; if (p_npc !== exp_npc)     begin n_fail++; $display("FAIL rand_npc[%0d] got %h want %h", c, p_npc, exp_npc); end
                n_cmp++; if (p_taken !== exp_taken) begin n_fail++; $display("FAIL rand_taken[%0d] got %0b want %0b", c, p_taken, exp_taken); end
            end
        end
        stall = 1'b0; flush = 1'b0; upd_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [31:0] m8;
        m8 = 32'hFFFF_FFF8;
        f_valid = 1'b0; upd_valid = 1'b1; upd_pc = 32'h40; upd_taken = 1'b1;
        repeat (3) tick();
        upd_valid = 1'b0;
        set_fetch(K_JAL, 32'h500, 32'h40, 5'd0, 32'd0);
        tick();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_cmp++; if (p_valid !== 1'b0)     begin n_fail++; $display("FAIL rstmid_valid got %0b want 0", p_valid); end
        n_cmp++; if (p_npc !== 32'd0)      begin n_fail++; $display("FAIL rstmid_npc got %h want 0", p_npc); end
        for (int i = 0; i < 64; i++) begin
            n_cmp++;
            if (dut.u_bht.cnt_q[i] !== 2'b01) begin n_fail++; $display("FAIL rstmid_cnt[%0d] got %b want 01", i, dut.u_bht.cnt_q[i]); end
        end
        @(negedge clk);
        rst_n = 1'b1;
        set_fetch(K_BR, 32'h40, m8, 5'd3, 32'd0);
        tick();
        n_cmp++; if (p_valid !== 1'b1)     begin n_fail++; $display("FAIL rstmid_resume_valid got %0b want 1", p_valid); end
        n_cmp++; if (p_taken !== 1'b0)     begin n_fail++; $display("FAIL rstmid_resume_taken got %0b want 0", p_taken); end
        n_cmp++; if (p_npc !== 32'h44)     begin n_fail++; $display("FAIL rstmid_resume_npc got %h want 00000044", p_npc); end
    endtask

    initial begin
        test_reset();
        test_jal();
        test_jalr();
        test_branch_training();
        test_collision();
        test_stall_flush();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter BHT_IDX_W, default 6, meaning log2 of the branch-history-table entry count (64 entries).
REQ-002 SHALL have parameter RESET_CNT, default 2'b01, meaning the counter value loaded at reset (weakly not-taken).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-005 SHALL have port f_valid  input  1  fetch slot carries an instruction.
REQ-006 SHALL have port f_pc  input  32  PC of the fetched instruction.
REQ-007 SHALL have port f_inst  input  32  fetched instruction word (lower halfword only is meaningful if compressed).
REQ-008 SHALL have port stall  input  1  hold the output stage.
REQ-009 SHALL have port flush  input  1  kill the output stage.
REQ-010 SHALL have port rs1pred  output  5  register index presented to the predictor register-copy read port.
REQ-011 SHALL have port data_rs1pred  input  32  register value returned combinationally for rs1pred.
REQ-012 SHALL have port upd_valid  input  1  resolved conditional branch from execute.
REQ-013 SHALL have port upd_pc  input  32  PC of the resolved branch.
REQ-014 SHALL have port upd_taken  input  1  actual branch outcome.
REQ-015 SHALL have port p_valid  output  1  prediction valid.
REQ-016 SHALL have port p_pc  output  32  PC of the predicted instruction.
REQ-017 SHALL have port p_npc  output  32  predicted next PC.
REQ-018 SHALL have port p_taken  output  1  control-flow redirect predicted.

Function
REQ-019 SHALL drive rs1pred = f_inst[19:15] combinationally, every cycle.
REQ-020 SHALL treat the rs1 value as 0 when rs1pred = 0, regardless of data_rs1pred.
REQ-021 SHALL classify the instruction by opcode f_inst[6:0]:
- JAL 1101111
- JALR 1100111
- BRANCH 1100011
- all others are sequential.
REQ-022 SHALL classify f_inst[1:0] != 2'b11 as compressed: npc = f_pc+2, taken = 0, no further decode.
REQ-023 SHALL compute p_npc as follows, with all sums modulo 2^32 (wrap-around, no overflow flag):
- JAL: f_pc + sign-extended J-immediate; taken = 1.
- JALR: (rs1 + sign-extended I-immediate) & ~1; taken = 1.
- BRANCH: f_pc + sign-extended B-immediate when the counter MSB = 1 (taken = 1), else f_pc+4 (taken = 0).
- Other: f_pc+4; taken = 0.
REQ-024 SHALL index the BHT with pc[BHT_IDX_W:1] for both lookup and update.
REQ-025 SHALL register the prediction with 1-cycle latency: p_* reflect f_* from the previous edge.
REQ-026 SHALL load the output stage when stall = 0; p_valid <= f_valid.
REQ-027 SHALL hold all p_* unchanged when stall = 1 and flush = 0.
REQ-028 SHALL clear p_valid when flush = 1 (flush has priority over stall); p_pc, p_npc and p_taken are don't-care after a flush.
REQ-029 SHALL update the BHT counter at upd_pc on each upd_valid edge, independent of stall and flush:
- saturating increment if upd_taken = 1, capped at 2'b11;
- saturating decrement if upd_taken = 0, floored at 2'b00.
REQ-030 SHALL return the pre-update counter value when a lookup and an update hit the same index in the same cycle (no bypass).

Reset
REQ-031 SHALL, while rst_n = 0:
- set p_valid = 0, p_pc = 0, p_npc = 0 and p_taken = 0;
- set every BHT counter to RESET_CNT.
REQ-032 SHALL apply reset asynchronously, so that an assertion mid-operation discards the in-flight prediction immediately.
REQ-033 SHALL resume normal operation on the first rising clk edge after rst_n deasserts.

Structure
REQ-034 SHALL place the opcode constants (JAL, JALR, BRANCH) and the 2-bit counter encodings in the shared core package.
REQ-035 SHALL implement the BHT as sub-module bht_counter_table:
- one combinational read port;
- one synchronous saturating-update port;
- asynchronous reset;
- flip-flop storage, because BRAM is disallowed due to the reset requirement.

Verification
REQ-036 SHALL cover the JAL case: f_pc = 0x100, inst = JAL with imm = +0x20 -> next cycle p_valid = 1, p_npc = 0x120, p_taken = 1.
REQ-037 SHALL cover the JALR and x0 cases:
- rs1 = 5, data_rs1pred = 0x2003, imm = +4 -> p_npc = 0x2006.
- rs1 = 0, data_rs1pred = 0xFFFF -> p_npc = imm & ~1.
REQ-038 SHALL cover counter training for a BRANCH at 0x40 with imm = -8:
- after reset -> p_npc = 0x44, p_taken = 0.
- after one upd_taken = 1 -> p_npc = 0x38, p_taken = 1.
- after 3 more taken updates then one not-taken -> still taken.
REQ-039 SHALL cover the same-cycle collision: lookup and not-taken update on the same index with counter = 2'b10 -> prediction taken; the following lookup -> not-taken.
REQ-040 SHALL cover stall, flush and wrap-around:
- stall = 1 for 3 cycles -> p_* unchanged.
- flush = 1 together with stall = 1 -> p_valid = 0.
- f_pc = 0xFFFFFFFE with a compressed instruction -> p_npc = 0x00000000.
REQ-041 SHALL cover reset mid-operation: rst_n pulsed low between edges -> p_valid = 0 immediately, and all counters read 2'b01.
